pwr_btn_seq: RTL and testbench

Power-button sequencing controller. It sits directly downstream of the power-button filter and consumes that block's three outputs: arm-enable, filtered press, and 4-second press. From these it drives the board rail-enable request, a fixed-width soft power-button pulse to the SoC, and a fault flag. The block runs entirely in the 32 kHz always-on domain of the CPLD.

---
 rtl/pwr_btn_seq.sv | 155 +++++++++++++++
 tb/tb_pwr_btn_seq.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwr_btn_seq.sv
// Power-button sequencing controller (32 kHz always-on domain).
//
// Consumes the power-button filter outputs and sequences the board rails.
// Outputs are registered and are decoded from the next state.
//
// Ports:
//   i_clk_32k        32.768 kHz always-on clock, the only clock
//   i_rst_n          asynchronous active-low reset
//   i_pwr_btn_en     filter arm-enable; presses ignored in IDLE while low
//   i_pwr_btn_press  filtered button-pressed level
//   i_pressed_4s     filtered held-about-4-s level
//   i_pwr_good       aggregate rail power-good (synchronous)
//   i_soc_off_req    SoC-initiated shutdown request (level)
//   o_pwr_on_req     rail enable request, 1 = rails on
//   o_soc_pwr_btn_n  active-low soft power-button pulse to the SoC
//   o_fault          sticky power-good timeout / loss flag
//   o_state          current state encoding, for debug
module pwr_btn_seq #(
  parameter int unsigned PULSE_W    = 3200,
  parameter int unsigned PG_TIMEOUT = 32768,
  parameter int unsigned OFF_HOLD   = 16384
) (
  input  logic       i_clk_32k,
  input  logic       i_rst_n,
  input  logic       i_pwr_btn_en,
  input  logic       i_pwr_btn_press,
  input  logic       i_pressed_4s,
  input  logic       i_pwr_good,
  input  logic       i_soc_off_req,
  output logic       o_pwr_on_req,
  output logic       o_soc_pwr_btn_n,
  output logic       o_fault,
  output logic [2:0] o_state
);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StPwrup    = 3'd1,
    StOn       = 3'd2,
    StSoftoff  = 3'd3,
    StForceoff = 3'd4,
    StOffhold  = 3'd5
  } state_e;

  // Terminal counts; the counter starts at 0 on state entry.
  localparam logic [15:0] PulseLast = 16'(PULSE_W - 1);
  localparam logic [15:0] PgLast    = 16'(PG_TIMEOUT - 1);
  localparam logic [15:0] HoldLast  = 16'(OFF_HOLD - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        press_q;
  logic        hist_q;
  logic        press_rise;
  logic        pwr_on_q, pwr_on_d;
  logic        soc_btn_n_q, soc_btn_n_d;
  logic        fault_q, fault_d;

  // The press history follows the button through reset: the first edge after reset only
  // loads the history, so a press held across reset release is never seen as a rise.
  assign press_rise = hist_q & i_pwr_btn_press & ~press_q;

  always_comb begin
    state_d = state_q;
    fault_d = fault_q;

    case (state_q)
      StIdle: begin
        if (press_rise && i_pwr_btn_en) begin
          state_d = StPwrup;
          fault_d = 1'b0;
        end
      end

      StPwrup: begin
        if (i_pwr_good) begin
          state_d = StOn;
        end else if (cnt_q == PgLast) begin
          state_d = StOffhold;
          fault_d = 1'b1;
        end
      end

      StOn, StSoftoff: begin
        // Power-good loss beats an SoC request, which beats a 4 s hold.
        if (!i_pwr_good) begin
          state_d = StOffhold;
          fault_d = 1'b1;
        end else if (i_soc_off_req) begin
          state_d = StOffhold;
        end else if (i_pressed_4s) begin
          state_d = StForceoff;
        end else if (state_q == StOn) begin
          if (press_rise) begin
            state_d = StSoftoff;
          end
        end else if (cnt_q == PulseLast) begin
          state_d = StOn;
        end
      end

      StForceoff: begin
        if (!i_pwr_btn_press && !i_pressed_4s) begin
          state_d = StOffhold;
        end
      end

      StOffhold: begin
        if (cnt_q == HoldLast) begin
          state_d = StIdle;
        end
      end

      // Unused encodings recover through the off-hold with rails down.
      default: state_d = StOffhold;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q inside {StPwrup, StSoftoff, StOffhold}) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end

    pwr_on_d    = state_d inside {StPwrup, StOn, StSoftoff};
    soc_btn_n_d = (state_d != StSoftoff);
  end

  always_ff @(posedge i_clk_32k or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      press_q     <= 1'b0;
      hist_q      <= 1'b0;
      pwr_on_q    <= 1'b0;
      soc_btn_n_q <= 1'b1;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      press_q     <= i_pwr_btn_press;
      hist_q      <= 1'b1;
      pwr_on_q    <= pwr_on_d;
      soc_btn_n_q <= soc_btn_n_d;
      fault_q     <= fault_d;
    end
  end

  assign o_pwr_on_req    = pwr_on_q;
  assign o_soc_pwr_btn_n = soc_btn_n_q;
  assign o_fault         = fault_q;
  assign o_state         = state_q;

endmodule

// File: tb/tb_pwr_btn_seq.sv
// Self-checking bench for pwr_btn_seq: directed scenarios with literal expectations,
// then randomized stimulus checked every cycle against a countdown-timer reference model.
module tb_pwr_btn_seq;

  localparam int unsigned PW  = 4;
  localparam int unsigned PGT = 8;
  localparam int unsigned OH  = 6;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       en     = 1'b0;
  logic       press  = 1'b0;
  logic       p4s    = 1'b0;
  logic       pg     = 1'b0;
  logic       offreq = 1'b0;
  logic       pwr_on;
  logic       soc_n;
  logic       fault;
  logic [2:0] st;

  int checks = 0;
  int passed = 0;
  bit done   = 1'b0;

  pwr_btn_seq #(
    .PULSE_W   (PW),
    .PG_TIMEOUT(PGT),
    .OFF_HOLD  (OH)
  ) dut (
    .i_clk_32k      (clk),
    .i_rst_n        (rst_n),
    .i_pwr_btn_en   (en),
    .i_pwr_btn_press(press),
    .i_pressed_4s   (p4s),
    .i_pwr_good     (pg),
    .i_soc_off_req  (offreq),
    .o_pwr_on_req   (pwr_on),
    .o_soc_pwr_btn_n(soc_n),
    .o_fault        (fault),
    .o_state        (st)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: mode number plus a countdown of cycles left in the timed modes.
  int m_st    = 0;
  int m_left  = 0;
  bit m_fault = 1'b0;
  bit m_prev  = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    bit rise;
    if (!rst_n) begin
      m_st    = 0;
      m_left  = 0;
      m_fault = 1'b0;
      m_prev  = press;  // history tracks the button during reset
    end else begin
      rise   = press && !m_prev;
      m_prev = press;
      case (m_st)
        0: if (rise && en) begin m_st = 1; m_left = PGT; m_fault = 1'b0; end
        1: begin
          if (pg) m_st = 2;
          else begin
            m_left--;
            if (m_left == 0) begin m_st = 5; m_left = OH; m_fault = 1'b1; end
          end
        end
        2, 3: begin
          if (!pg) begin m_st = 5; m_left = OH; m_fault = 1'b1; end
          else if (offreq) begin m_st = 5; m_left = OH; end
          else if (p4s) m_st = 4;
          else if (m_st == 2) begin
            if (rise) begin m_st = 3; m_left = PW; end
          end else begin
            m_left--;
            if (m_left == 0) m_st = 2;
          end
        end
        4: if (!press && !p4s) begin m_st = 5; m_left = OH; end
        default: begin
          m_left--;
          if (m_left == 0) m_st = 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (!done) begin
      check("cyc_state", st, m_st);
      check("cyc_pwr_on", pwr_on, (m_st >= 1 && m_st <= 3) ? 1 : 0);
      check("cyc_soc_n", soc_n, (m_st == 3) ? 0 : 1);
      check("cyc_fault", fault, m_fault);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt;
    int pg_mode;

    // Reset state
    repeat (3) tick();
    check("rst_state", st, 0);
    check("rst_pwr_on", pwr_on, 0);
    check("rst_soc_n", soc_n, 1);
    check("rst_fault", fault, 0);
    rst_n = 1'b1;
    en    = 1'b1;
    repeat (2) tick();

    // Normal power-up
    press = 1'b1;
    tick();
    check("pu_pwr_on", pwr_on, 1);
    check("pu_state1", st, 1);
    press = 1'b0;
    repeat (2) tick();
    pg = 1'b1;
    tick();
    check("pu_state2", st, 2);
    check("pu_fault", fault, 0);

    // Soft-off pulse, press held throughout
    press = 1'b1;
    tick();
    check("so_state", st, 3);
    check("so_soc_n", soc_n, 0);
    cnt = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (soc_n) break;
      cnt++;
    end
    check("so_low_cycles", cnt, 4);
    check("so_back_on", st, 2);
    repeat (3) tick();
    check("so_no_repeat", soc_n, 1);
    check("so_still_on", st, 2);
    press = 1'b0;
    tick();

    // Force-off
    press = 1'b1;
    tick();
    check("fo_soft", st, 3);
    p4s = 1'b1;
    tick();
    check("fo_state", st, 4);
    check("fo_pwr_on", pwr_on, 0);
    tick();
    check("fo_hold", st, 4);
    press = 1'b0;
    p4s   = 1'b0;
    tick();
    check("fo_offhold", st, 5);
    repeat (5) tick();
    check("fo_offhold_end", st, 5);
    tick();
    check("fo_idle", st, 0);
    repeat (3) tick();
    check("fo_no_auto", pwr_on, 0);

    // Power-good timeout
    pg    = 1'b0;
    press = 1'b1;
    tick();
    check("to_pwr_on", pwr_on, 1);
    press = 1'b0;
    cnt   = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!pwr_on) break;
      cnt++;
    end
    check("to_high_cycles", cnt, 8);
    check("to_fault", fault, 1);
    check("to_state", st, 5);
    repeat (5) tick();
    check("to_offhold", st, 5);
    tick();
    check("to_idle", st, 0);
    press = 1'b1;
    tick();
    check("to_fault_clr", fault, 0);
    check("to_repwr", st, 1);
    press = 1'b0;
    pg    = 1'b1;
    tick();
    check("to_on", st, 2);

    // Abort soft-off by power-good loss at count 1
    press = 1'b1;
    tick();
    press = 1'b0;
    tick();
    pg = 1'b0;
    tick();
    check("ab_pg_soc_n", soc_n, 1);
    check("ab_pg_pwr_on", pwr_on, 0);
    check("ab_pg_fault", fault, 1);
    check("ab_pg_state", st, 5);
    pg = 1'b1;
    repeat (6) tick();
    check("ab_pg_idle", st, 0);
    press = 1'b1;
    tick();
    press = 1'b0;
    tick();
    check("ab_re_on", st, 2);

    // Abort soft-off by SoC request at count 1
    press = 1'b1;
    tick();
    press = 1'b0;
    tick();
    offreq = 1'b1;
    tick();
    check("ab_req_soc_n", soc_n, 1);
    check("ab_req_pwr_on", pwr_on, 0);
    check("ab_req_fault", fault, 0);
    check("ab_req_state", st, 5);
    offreq = 1'b0;
    repeat (6) tick();

    // Async reset in SOFTOFF, press held through release
    press = 1'b1;
    tick();
    press = 1'b0;
    tick();
    press = 1'b1;
    tick();
    check("ar_soft", st, 3);
    #2 rst_n = 1'b0;
    #1;
    check("ar_pwr_on", pwr_on, 0);
    check("ar_soc_n", soc_n, 1);
    check("ar_state", st, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    check("ar_no_pwrup", st, 0);
    check("ar_no_pwr_on", pwr_on, 0);
    press = 1'b0;
    tick();

    // Randomized traffic
    pg_mode = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) pg_mode = $urandom_range(0, 2);
      if ($urandom_range(0, 599) == 0) begin
        #2 rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
      end
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 4) == 0) press = ~press;
      p4s    = press && ($urandom_range(0, 15) == 0);
      offreq = ($urandom_range(0, 59) == 0);
      case (pg_mode)
        0: pg = ($urandom_range(0, 63) != 0);
        1: pg = ($urandom_range(0, 9) == 0);
        default: pg = ($urandom_range(0, 1) == 0);
      endcase
      tick();
    end

    done = 1'b1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
